// File: rtl/s2_receiver.sv
// s2_receiver: rebuilds an 18x8 block from 8 bit-column serial packets and writes it to RB2.
module s2_receiver #(
  parameter int WORDS = 18,
  parameter int PKTS  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sen,
  input  logic       sd,
  output logic       RB2_RW,
  output logic [4:0] RB2_A,
  output logic [7:0] RB2_D,
  output logic       S2_done
);
  typedef enum logic [1:0] {RX, WRITE, DONE} state_t;
  state_t state, state_nxt;
  logic [20:0] sr;
  logic [4:0] bc;
  logic bad;
  logic [7:0] mem [WORDS];
  logic [PKTS-1:0] rmask;
  logic last;
  assign last = RB2_A == 5'(WORDS - 1);
  always_comb begin
    state_nxt = state;
    if (state == RX) state_nxt = &rmask ? WRITE : RX;
    else if (state == WRITE) state_nxt = (!RB2_RW && last) ? DONE : WRITE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RX;
    else state <= state_nxt;
  // RB2_A stays 0 from reset until WRITE, so the first write cycle only drops RB2_RW
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sr <= '0;
      bc <= '0;
      bad <= 1'b0;
      rmask <= '0;
      RB2_RW <= 1'b1;
      RB2_A <= '0;
      RB2_D <= '0;
      S2_done <= 1'b0;
      for (int j = 0; j < WORDS; j++) mem[j] <= '0;
    end else begin
      case (state)
        RX:
          if (!sen) begin
            if (bc < 5'd21) begin
              sr <= {sr[19:0], sd};
              bc <= bc + 5'd1;
            end else bad <= 1'b1;
          end else begin
            if (bc == 5'd21 && !bad) begin
              for (int j = 0; j < WORDS; j++) mem[j][~sr[20:18]] <= sr[j];
              rmask[sr[20:18]] <= 1'b1;
            end
            bc <= '0;
            bad <= 1'b0;
          end
        WRITE:
          if (RB2_RW) begin
            RB2_RW <= 1'b0;
            RB2_D <= mem[0];
          end else if (last) begin
            RB2_RW <= 1'b1;
            S2_done <= 1'b1;
          end else begin
            RB2_A <= RB2_A + 5'd1;
            RB2_D <= mem[RB2_A + 5'd1];
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_s2_receiver.sv
// tb_s2_receiver: directed self-checking bench for s2_receiver.
module tb_s2_receiver;
  logic clk = 1'b0, rst = 1'b0, sen = 1'b1, sd = 1'b0;
  logic RB2_RW, S2_done;
  logic [4:0] RB2_A;
  logic [7:0] RB2_D;
  int checks = 0, errors = 0, wr_cnt = 0;
  logic [7:0] exp_b [18];
  logic [4:0] log_a [256];
  logic [7:0] log_d [256];

  s2_receiver dut (.clk(clk), .rst(rst), .sen(sen), .sd(sd), .RB2_RW(RB2_RW),
                   .RB2_A(RB2_A), .RB2_D(RB2_D), .S2_done(S2_done));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst && !RB2_RW) begin
      log_a[wr_cnt[7:0]] = RB2_A;
      log_d[wr_cnt[7:0]] = RB2_D;
      wr_cnt++;
    end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bits(input logic [23:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sen = 1'b0;
      sd = bits[23-i];
    end
    @(negedge clk);
    sen = 1'b1;
    sd = 1'b0;
  endtask

  function automatic logic [17:0] column(input logic [2:0] a);
    logic [17:0] d;
    for (int j = 0; j < 18; j++) d[j] = exp_b[j][7-int'(a)];
    return d;
  endfunction

  task automatic send_pkt(input logic [2:0] a);
    send_bits({a, column(a), 3'b000}, 21);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    sen = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rw", RB2_RW, 1);
    chk("rst_a", RB2_A, 0);
    chk("rst_d", RB2_D, 0);
    chk("rst_done", S2_done, 0);
    rst = 1'b1;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!S2_done && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", S2_done, 1);
    chk("done_rw", RB2_RW, 1);
  endtask

  task automatic check_block(input string tag, input int base);
    chk({tag, "_count"}, wr_cnt - base, 18);
    for (int i = 0; i < 18; i++) begin
      chk({tag, "_addr"}, log_a[base+i], i);
      chk({tag, "_data"}, log_d[base+i], exp_b[i]);
    end
  endtask

  initial begin
    int base;
    logic [2:0] order [8];
    do_reset();
    // full block, in address order, with WRITE entry latency checked
    for (int j = 0; j < 18; j++) exp_b[j] = 8'((j * 13 + 5) % 256);
    base = wr_cnt;
    for (int a = 0; a < 8; a++) send_pkt(3'(a));
    @(negedge clk);
    chk("lat_commit_rw", RB2_RW, 1);
    @(negedge clk);
    chk("lat_state_rw", RB2_RW, 1);
    @(negedge clk);
    chk("lat_first_rw", RB2_RW, 0);
    chk("lat_first_a", RB2_A, 0);
    wait_done();
    check_block("full", base);
    chk("done_a17", RB2_A, 17);
    // packets after done are ignored
    base = wr_cnt;
    send_pkt(3'd0);
    send_pkt(3'd1);
    repeat (4) @(negedge clk);
    chk("post_writes", wr_cnt - base, 0);
    chk("post_rw", RB2_RW, 1);
    chk("post_done", S2_done, 1);
    // reset mid-packet, then out-of-order block
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      sen = 1'b0;
      sd = 1'b1;
    end
    do_reset();
    for (int j = 0; j < 18; j++) exp_b[j] = 8'hA5;
    order = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
    base = wr_cnt;
    for (int i = 0; i < 8; i++) send_pkt(order[i]);
    wait_done();
    check_block("ooo", base);
    // duplicate address overwrites its column
    do_reset();
    base = wr_cnt;
    send_bits({3'd2, 18'h3FFFF, 3'b000}, 21);
    send_bits({3'd2, 18'h00000, 3'b000}, 21);
    for (int a = 0; a < 7; a++)
      if (a != 2) send_bits({3'(a), 18'h3FFFF, 3'b000}, 21);
    repeat (6) @(negedge clk);
    chk("dup_early", wr_cnt - base, 0);
    chk("dup_early_rw", RB2_RW, 1);
    send_bits({3'd7, 18'h3FFFF, 3'b000}, 21);
    for (int j = 0; j < 18; j++) exp_b[j] = 8'hDF;
    wait_done();
    check_block("dup", base);
    // short and overlong packets are discarded
    do_reset();
    for (int j = 0; j < 18; j++) exp_b[j] = 8'h3C ^ 8'(j);
    base = wr_cnt;
    for (int a = 0; a < 8; a++)
      if (a != 6) send_pkt(3'(a));
    send_bits({3'd0, ~column(3'd0), 3'b101}, 15);
    send_bits({3'd0, ~column(3'd0), 3'b101}, 24);
    send_bits({3'd6, ~column(3'd6), 3'b111}, 24);
    repeat (6) @(negedge clk);
    chk("bad_early", wr_cnt - base, 0);
    chk("bad_early_done", S2_done, 0);
    send_pkt(3'd6);
    wait_done();
    check_block("bad", base);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
